ps2_host_port: RTL and testbench

PS2_HOST_PORT -- requirements
Module: ps2_host_port

---
 rtl/ps2_host_port.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_ps2_host_port.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_port.sv
// ps2_host_port
//
// PS/2 host-side port. It receives device frames into a small
// first-word-fall-through FIFO and transmits host-to-device command bytes.
// Both PS/2 lines are open-drain: the block either pulls a line low or
// releases it, and never drives it high.
//
// Ports
//   clk, rst     system clock and synchronous active-high reset
//   ps2_clk      open-drain PS/2 clock line
//   ps2_data     open-drain PS/2 data line
//   tx_stb       one-cycle request to send tx_data, accepted only while tx_ready=1
//   tx_data      byte to transmit
//   tx_ready     block is idle and will accept tx_stb
//   tx_done      one-cycle pulse at the end of every transmit
//   tx_err       qualifies tx_done: no acknowledge or timeout
//   rx_rd        pops the FIFO head when rx_valid=1
//   rx_valid     FIFO is not empty
//   rx_data      FIFO head, or 0 while the FIFO is empty
//   rx_err       one-cycle pulse on a bad or timed-out receive frame
//   rx_ovf       sticky flag for a received byte lost to a full FIFO
module ps2_host_port #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FILTER_LEN     = 4,
   parameter int RX_DEPTH       = 8
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   input  logic       tx_stb,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       rx_rd,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_err,
   output logic       rx_ovf
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int FLT_W   = $clog2(FILTER_LEN + 1);
   localparam int AW      = $clog2(RX_DEPTH);
   localparam int AW1     = AW + 1;
   localparam logic [AW:0] FULL_COUNT = AW1'(RX_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      RX,
      TX_INH,
      TX_RTS,
      TX_SHIFT,
      TX_ACK,
      TX_END
   } state_t;

   logic [1:0]       pin_raw;
   logic [1:0]       sync_a;
   logic [1:0]       sync_b;
   logic [1:0]       filt;
   logic [FLT_W-1:0] flt_cnt [2];
   logic             clk_f;
   logic             data_f;
   logic             clk_f_d;
   logic             fall;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bit_cnt;
   logic [7:0]       rx_sh;
   logic             rx_par;
   logic [8:0]       tx_sh;
   logic             ack_bad;
   logic             clk_low;
   logic             data_low;
   logic             push_req;
   logic [7:0]       push_byte;
   logic             timeout;

   logic [7:0]       mem [RX_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             pop;
   logic             do_push;

   // Open-drain pin drivers: a line is either pulled low or left floating.
   assign ps2_clk  = clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = data_low ? 1'b0 : 1'bz;

   assign pin_raw = {ps2_data, ps2_clk};
   assign clk_f   = filt[0];
   assign data_f  = filt[1];
   assign fall    = clk_f_d & ~clk_f;

   // Bit 0 is the clock line, bit 1 the data line. Each passes two
   // synchroniser flops and then a filter that only changes its output after
   // FILTER_LEN consecutive samples disagree with it. Everything starts at 1
   // (released bus) so that reset never creates a false falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a  <= 2'b11;
         sync_b  <= 2'b11;
         filt    <= 2'b11;
         clk_f_d <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            flt_cnt[i] <= '0;
         end
      end else begin
         sync_a  <= pin_raw;
         sync_b  <= sync_a;
         clk_f_d <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] == filt[i]) begin
               flt_cnt[i] <= '0;
            end else if (flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
               filt[i]    <= sync_b[i];
               flt_cnt[i] <= '0;
            end else begin
               flt_cnt[i] <= flt_cnt[i] + 1'b1;
            end
         end
      end
   end

   // The watchdog fires once TIMEOUT_CYCLES cycles have gone by without a
   // clock fall. The same counter times the inhibit period in TX_INH.
   assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Main protocol FSM. The counter is cleared on every state entry. It is
   // cleared on falls only in the states that watch for a timeout. During
   // TX_INH the host pulls the clock low itself, and that fall must not
   // restart the inhibit count. Every transmit, good or bad, ends with one
   // tx_done pulse. A received frame goes to the FIFO through push_req one
   // cycle after its stop-bit fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         rx_sh     <= '0;
         rx_par    <= 1'b0;
         tx_sh     <= '0;
         ack_bad   <= 1'b0;
         clk_low   <= 1'b0;
         data_low  <= 1'b0;
         tx_done   <= 1'b0;
         tx_err    <= 1'b0;
         rx_err    <= 1'b0;
         push_req  <= 1'b0;
         push_byte <= '0;
      end else begin
         tx_done  <= 1'b0;
         tx_err   <= 1'b0;
         rx_err   <= 1'b0;
         push_req <= 1'b0;
         case (state)
            IDLE: begin
               cnt      <= '0;
               bit_cnt  <= '0;
               clk_low  <= 1'b0;
               data_low <= 1'b0;
               if (tx_stb) begin
                  tx_sh   <= {~^tx_data, tx_data};
                  clk_low <= 1'b1;
                  state   <= TX_INH;
               end else if (fall && !data_f) begin
                  state <= RX;
               end
            end
            RX: begin
               if (fall) begin
                  cnt     <= '0;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt < 4'd8) begin
                     rx_sh <= {data_f, rx_sh[7:1]};
                  end else if (bit_cnt == 4'd8) begin
                     rx_par <= data_f;
                  end else begin
                     state <= IDLE;
                     if (data_f && (^{rx_sh, rx_par})) begin
                        push_req  <= 1'b1;
                        push_byte <= rx_sh;
                     end else begin
                        rx_err <= 1'b1;
                     end
                  end
               end else if (timeout) begin
                  state  <= IDLE;
                  rx_err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            TX_INH: begin
               if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                  cnt      <= '0;
                  data_low <= 1'b1;
                  state    <= TX_RTS;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            TX_RTS: begin
               clk_low <= 1'b0;
               cnt     <= '0;
               bit_cnt <= '0;
               state   <= TX_SHIFT;
            end
            TX_SHIFT: begin
               if (fall) begin
                  cnt     <= '0;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt < 4'd9) begin
                     data_low <= ~tx_sh[0];
                     tx_sh    <= {1'b1, tx_sh[8:1]};
                  end else begin
                     data_low <= 1'b0;
                     state    <= TX_ACK;
                  end
               end else if (timeout) begin
                  clk_low  <= 1'b0;
                  data_low <= 1'b0;
                  tx_done  <= 1'b1;
                  tx_err   <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            TX_ACK: begin
               if (fall) begin
                  cnt     <= '0;
                  ack_bad <= data_f;
                  state   <= TX_END;
               end else if (timeout) begin
                  clk_low  <= 1'b0;
                  data_low <= 1'b0;
                  tx_done  <= 1'b1;
                  tx_err   <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            TX_END: begin
               if (clk_f && data_f) begin
                  tx_done <= 1'b1;
                  tx_err  <= ack_bad;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign tx_ready = (state == IDLE);

   // FIFO flags. A push into a full FIFO is still accepted when a pop
   // happens in the same cycle, because that pop frees the slot.
   assign full     = (count == FULL_COUNT);
   assign pop      = rx_rd && rx_valid;
   assign do_push  = push_req && (!full || pop);
   assign rx_valid = (count != '0);
   assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

   // FIFO pointers and occupancy. The pointers wrap naturally because
   // RX_DEPTH is a power of two. rx_ovf stays set until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rx_ovf <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !do_push) begin
            count <= count - 1'b1;
         end
         if (push_req && !do_push) begin
            rx_ovf <= 1'b1;
         end
      end
   end

   // FIFO storage has no reset. Its contents are hidden behind rx_valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_byte;
      end
   end

endmodule

// File: tb/tb_ps2_host_port.sv
// tb_ps2_host_port
//
// Directed bench for ps2_host_port. A behavioural PS/2 device sits on the
// open-drain lines (pulled up here). The bench sends frames to the host,
// clocks host transmits and optionally acknowledges them, and checks every
// result against a hand-computed value.
module tb_ps2_host_port;

   localparam int INHIBIT = 5000;
   localparam int TIMEOUT = 2000;
   localparam int HP      = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_stb;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_err;
   logic       rx_rd;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_err;
   logic       rx_ovf;
   wire        ps2_clk;
   wire        ps2_data;

   logic       devClkLow  = 1'b0;
   logic       devDataLow = 1'b0;

   int         checks      = 0;
   int         failures    = 0;
   int         rxErrCount  = 0;
   int         txDoneCount = 0;
   logic       lastTxErr   = 1'b0;

   assign ps2_clk  = devClkLow  ? 1'b0 : 1'bz;
   assign ps2_data = devDataLow ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);

   ps2_host_port #(
      .INHIBIT_CYCLES (INHIBIT),
      .TIMEOUT_CYCLES (TIMEOUT),
      .FILTER_LEN     (4),
      .RX_DEPTH       (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .tx_stb   (tx_stb),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx_done  (tx_done),
      .tx_err   (tx_err),
      .rx_rd    (rx_rd),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_err   (rx_err),
      .rx_ovf   (rx_ovf)
   );

   // 10-unit system clock.
   always #5 clk = ~clk;

   // Pulse monitors sample on the falling clock edge, away from the edge that
   // updates the DUT registers.
   always @(negedge clk) begin
      if (rx_err) begin
         rxErrCount <= rxErrCount + 1;
      end
      if (tx_done) begin
         txDoneCount <= txDoneCount + 1;
         lastTxErr   <= tx_err;
      end
   end

   // Hard stop in case a step never returns.
   initial begin
      repeat (80000) @(posedge clk);
      $display("[TB] FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drives the host-side inputs for exactly one clock cycle.
   task automatic applyStimulus(input logic stb, input logic [7:0] data, input logic rd);
      tx_stb  = stb;
      tx_data = data;
      rx_rd   = rd;
      tick(1);
      tx_stb  = 1'b0;
      rx_rd   = 1'b0;
   endtask

   // Device-to-host frame: start, 8 data bits LSB first, odd parity, stop.
   // nBits < 11 cuts the frame short to provoke a timeout.
   task automatic sendFrame(input logic [7:0] b, input logic badParity, input int nBits);
      logic [10:0] frame;
      frame = {1'b1, (~^b) ^ badParity, b, 1'b0};
      for (int i = 0; i < nBits; i++) begin
         devDataLow = ~frame[i];
         tick(HP);
         devClkLow = 1'b1;
         tick(HP);
         devClkLow = 1'b0;
      end
      devDataLow = 1'b0;
      tick(HP);
   endtask

   // Device side of a host transmit: 10 clock pulses to collect d0..d7,
   // parity and stop, then an 11th pulse during which the data line is
   // optionally pulled low as the acknowledge.
   task automatic deviceReceive(input logic doAck, output logic [9:0] bitsSeen);
      bitsSeen = '0;
      for (int i = 0; i < 11; i++) begin
         if (i == 10 && doAck) begin
            devDataLow = 1'b1;
         end
         tick(HP);
         devClkLow = 1'b1;
         tick(HP - 1);
         if (i < 10) begin
            bitsSeen[i] = ps2_data;
         end
         devClkLow = 1'b0;
         tick(1);
      end
      tick(HP);
      devDataLow = 1'b0;
      tick(HP);
   endtask

   // A complete host transmit. It requests the send, measures how long the
   // host holds the clock low, checks that data is low (request to send)
   // when the clock is released, and lets the device clock the frame in.
   task automatic runTransmit(input logic [7:0] b, input logic doAck, input string tag);
      int         lowCycles;
      logic       rtsSeen;
      logic [9:0] bitsSeen;
      int         doneBefore;
      doneBefore = txDoneCount;
      checkOutput({tag, "_ready_before"}, tx_ready, 1);
      applyStimulus(1'b1, b, 1'b0);
      checkOutput({tag, "_ready_busy"}, tx_ready, 0);
      lowCycles = 0;
      while (ps2_clk === 1'b0 && lowCycles < INHIBIT + 1000) begin
         lowCycles++;
         tick(1);
      end
      checkOutput({tag, "_inhibit_len"}, (lowCycles >= INHIBIT && lowCycles <= INHIBIT + 1), 1);
      rtsSeen = (ps2_data === 1'b0);
      checkOutput({tag, "_rts_data_low"}, rtsSeen, 1);
      deviceReceive(doAck, bitsSeen);
      checkOutput({tag, "_bits"}, bitsSeen, 10'h3ED);
      checkOutput({tag, "_done_count"}, txDoneCount - doneBefore, 1);
      checkOutput({tag, "_err"}, lastTxErr, doAck ? 0 : 1);
      checkOutput({tag, "_ready_after"}, tx_ready, 1);
   endtask

   initial begin
      int errBefore;
      int doneBefore;
      int elapsed;

      rst     = 1'b1;
      tx_stb  = 1'b0;
      tx_data = 8'h00;
      rx_rd   = 1'b0;
      $display("[TB] reset");
      tick(3);
      rst = 1'b0;
      checkOutput("rst_tx_ready", tx_ready, 1);
      checkOutput("rst_rx_valid", rx_valid, 0);
      checkOutput("rst_rx_data", rx_data, 0);
      checkOutput("rst_tx_done", tx_done, 0);
      checkOutput("rst_tx_err", tx_err, 0);
      checkOutput("rst_rx_err", rx_err, 0);
      checkOutput("rst_rx_ovf", rx_ovf, 0);
      checkOutput("rst_clk_released", ps2_clk, 1);
      checkOutput("rst_data_released", ps2_data, 1);
      tick(10);

      $display("[TB] receive 0x1C good parity");
      errBefore = rxErrCount;
      sendFrame(8'h1C, 1'b0, 11);
      tick(5);
      checkOutput("rx_good_valid", rx_valid, 1);
      checkOutput("rx_good_data", rx_data, 8'h1C);
      checkOutput("rx_good_no_err", rxErrCount - errBefore, 0);
      tick(3);
      checkOutput("rx_good_stable", rx_data, 8'h1C);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("rx_pop_empty", rx_valid, 0);

      $display("[TB] receive 0x1C bad parity");
      errBefore = rxErrCount;
      sendFrame(8'h1C, 1'b1, 11);
      tick(5);
      checkOutput("rx_bad_err_pulses", rxErrCount - errBefore, 1);
      checkOutput("rx_bad_valid", rx_valid, 0);

      $display("[TB] transmit 0xED with ack");
      runTransmit(8'hED, 1'b1, "tx_ack");
      tick(10);

      $display("[TB] transmit 0xED without ack");
      runTransmit(8'hED, 1'b0, "tx_noack");
      tick(10);

      $display("[TB] receive timeout after 4 data bits");
      errBefore = rxErrCount;
      sendFrame(8'h1C, 1'b0, 5);
      elapsed = 0;
      while (rxErrCount == errBefore && elapsed < TIMEOUT + 500) begin
         elapsed++;
         tick(1);
      end
      checkOutput("to_err_pulse", rxErrCount - errBefore, 1);
      checkOutput("to_delay", (elapsed >= TIMEOUT - 100 && elapsed <= TIMEOUT + 50), 1);
      checkOutput("to_idle", tx_ready, 1);
      checkOutput("to_clk_released", ps2_clk, 1);
      checkOutput("to_data_released", ps2_data, 1);
      checkOutput("to_no_push", rx_valid, 0);
      tick(10);

      $display("[TB] fill FIFO with 0x01..0x09");
      for (int k = 1; k <= 8; k++) begin
         sendFrame(8'(k), 1'b0, 11);
      end
      tick(5);
      checkOutput("ovf_clear_at_full", rx_ovf, 0);
      sendFrame(8'h09, 1'b0, 11);
      tick(5);
      checkOutput("ovf_set", rx_ovf, 1);
      for (int k = 1; k <= 8; k++) begin
         checkOutput($sformatf("ovf_read_%0d", k), rx_data, 32'(k));
         applyStimulus(1'b0, 8'h00, 1'b1);
      end
      checkOutput("ovf_drained", rx_valid, 0);
      checkOutput("ovf_sticky", rx_ovf, 1);

      $display("[TB] reset in the middle of a transmit");
      doneBefore = txDoneCount;
      applyStimulus(1'b1, 8'h55, 1'b0);
      tick(100);
      checkOutput("midrst_clk_held", ps2_clk, 0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checkOutput("midrst_clk_released", ps2_clk, 1);
      checkOutput("midrst_data_released", ps2_data, 1);
      checkOutput("midrst_ready", tx_ready, 1);
      checkOutput("midrst_ovf_cleared", rx_ovf, 0);
      tick(50);
      checkOutput("midrst_no_done", txDoneCount - doneBefore, 0);
      checkOutput("midrst_no_push", rx_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
